// File: rtl/fp_addsub_prealign_pkg.sv
// Shared binary32 field layout, exception bit indices and pipeline bundle types
// for the FP add/sub pre-alignment front end.
package fp_addsub_prealign_pkg;

  localparam int SIGN_BIT  = 31;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 23;
  localparam int FRAC_MSB  = 22;
  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int MANT_W    = 24;
  localparam int ALIGN_W   = 27;
  localparam int EXC_W     = 5;

  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam logic [7:0] EXP_ZERO = 8'h00;
  localparam int         BIAS    = 127;

  localparam int EXC_INF_MINUS_INF = 4;
  localparam int EXC_ANY_NAN       = 3;
  localparam int EXC_A_INF         = 2;
  localparam int EXC_B_INF         = 1;
  localparam int EXC_ANY           = 0;

  typedef struct packed {
    logic                sa;
    logic                sb;
    logic                ctrl;
    logic                op_eff;
    logic                max_ab;
    logic [EXP_W-1:0]    emax;
    logic [MANT_W-1:0]   mmax;
    logic [MANT_W-1:0]   mmin;
    logic [EXP_W-1:0]    shift;
    logic [EXC_W-1:0]    exc;
  } stage1_t;

  typedef struct packed {
    logic                sa;
    logic                sb;
    logic                ctrl;
    logic                op_eff;
    logic                max_ab;
    logic [EXP_W-1:0]    emax;
    logic [MANT_W-1:0]   mmax;
    logic [MANT_W-1:0]   mmin;
    logic [2:0]          grs;
    logic [EXC_W-1:0]    exc;
  } stage2_t;

  // Denormals are flushed: a zero exponent yields an all-zero significand.
  function automatic logic [MANT_W-1:0] significand(input logic [31:0] x);
    logic [MANT_W-1:0] m;
    if (x[EXP_MSB:EXP_LSB] == EXP_ZERO) begin
      m = 24'h000000;
    end else begin
      m = {1'b1, x[FRAC_MSB:0]};
    end
    return m;
  endfunction

endpackage

// File: rtl/fp_addsub_prealign_if.sv
// Upstream operand handshake and downstream aligned-field handshake of the
// FP add/sub pre-alignment stage.
interface fp_addsub_prealign_if;
  import fp_addsub_prealign_pkg::*;

  logic                InValid;
  logic                InReady;
  logic [31:0]         A;
  logic [31:0]         B;
  logic                Ctrl;
  logic                OutValid;
  logic                OutReady;
  logic                Sa;
  logic                Sb;
  logic                CtrlO;
  logic                OpEff;
  logic                MaxAB;
  logic [EXP_W-1:0]    Emax;
  logic [MANT_W-1:0]   Mmax;
  logic [MANT_W-1:0]   Mmin;
  logic [2:0]          GRS;
  logic [EXC_W-1:0]    InputExc;

  modport master (
    output InValid, A, B, Ctrl, OutReady,
    input  InReady, OutValid, Sa, Sb, CtrlO, OpEff, MaxAB, Emax, Mmax, Mmin, GRS, InputExc
  );

  modport slave (
    input  InValid, A, B, Ctrl, OutReady,
    output InReady, OutValid, Sa, Sb, CtrlO, OpEff, MaxAB, Emax, Mmax, Mmin, GRS, InputExc
  );

endinterface

// File: rtl/fp_addsub_prealign_shifter.sv
// Right-aligns the smaller significand into {mant, G, R, S}; shifts of 27 or
// more saturate, leaving only the sticky bit.
module fp_align_shifter
  import fp_addsub_prealign_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic [EXP_W-1:0]  shift,
  output logic [MANT_W-1:0] mant_aligned,
  output logic [2:0]        grs
);

  logic [ALIGN_W-1:0] ext_s;
  logic [ALIGN_W-1:0] shifted_s;
  logic [ALIGN_W-1:0] lost_mask_s;
  logic               sticky_s;

  // Alignment shift with sticky collection of every bit pushed below R.
  always_comb begin
    ext_s        = {mant, 3'b000};
    shifted_s    = 27'd0;
    lost_mask_s  = 27'd0;
    sticky_s     = 1'b0;
    mant_aligned = 24'd0;
    grs          = 3'b000;
    if (shift >= 8'd27) begin
      mant_aligned = 24'd0;
      grs          = {2'b00, |mant};
    end else begin
      shifted_s    = ext_s >> shift;
      lost_mask_s  = ~({ALIGN_W{1'b1}} << shift);
      sticky_s     = |(ext_s & lost_mask_s);
      mant_aligned = shifted_s[ALIGN_W-1:3];
      grs          = {shifted_s[2:1], shifted_s[0] | sticky_s};
    end
  end

endmodule

// File: rtl/fp_addsub_prealign.sv
// Two-stage binary32 add/sub front end: stage 1 unpacks, classifies and orders
// the operands; stage 2 aligns the smaller significand and holds the outputs.
module fp_addsub_prealign
  import fp_addsub_prealign_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  fp_addsub_prealign_if.slave   io
);

  logic              v1_r;
  logic              v2_r;
  logic              adv1_s;
  logic              adv2_s;
  stage1_t           s1_next_s;
  stage1_t           s1_r;
  stage2_t           s2_r;
  logic [EXP_W-1:0]  e_a_s;
  logic [EXP_W-1:0]  e_b_s;
  logic [EXP_W-1:0]  emin_s;
  logic              swap_s;
  logic              a_inf_s;
  logic              b_inf_s;
  logic              a_nan_s;
  logic              b_nan_s;
  logic [MANT_W-1:0] mmin_aligned_s;
  logic [2:0]        grs_s;

  assign adv2_s     = ~v2_r | io.OutReady;
  assign adv1_s     = ~v1_r | adv2_s;
  assign io.InReady = adv1_s;

  // Stage-1 unpack, classification and magnitude ordering.
  always_comb begin
    s1_next_s = '0;
    e_a_s     = io.A[EXP_MSB:EXP_LSB];
    e_b_s     = io.B[EXP_MSB:EXP_LSB];
    a_inf_s   = (e_a_s == EXP_MAX) && (io.A[FRAC_MSB:0] == 23'd0);
    b_inf_s   = (e_b_s == EXP_MAX) && (io.B[FRAC_MSB:0] == 23'd0);
    a_nan_s   = (e_a_s == EXP_MAX) && (io.A[FRAC_MSB:0] != 23'd0);
    b_nan_s   = (e_b_s == EXP_MAX) && (io.B[FRAC_MSB:0] != 23'd0);
    // Ties keep A as the larger operand.
    swap_s    = io.B[EXP_MSB:0] > io.A[EXP_MSB:0];

    s1_next_s.sa     = io.A[SIGN_BIT];
    s1_next_s.sb     = io.B[SIGN_BIT];
    s1_next_s.ctrl   = io.Ctrl;
    s1_next_s.op_eff = io.Ctrl ^ io.A[SIGN_BIT] ^ io.B[SIGN_BIT];
    s1_next_s.max_ab = swap_s;
    if (swap_s) begin
      s1_next_s.emax = e_b_s;
      s1_next_s.mmax = significand(io.B);
      s1_next_s.mmin = significand(io.A);
      emin_s         = e_a_s;
    end else begin
      s1_next_s.emax = e_a_s;
      s1_next_s.mmax = significand(io.A);
      s1_next_s.mmin = significand(io.B);
      emin_s         = e_b_s;
    end
    s1_next_s.shift = s1_next_s.emax - emin_s;

    s1_next_s.exc[EXC_INF_MINUS_INF] = a_inf_s & b_inf_s & s1_next_s.op_eff;
    s1_next_s.exc[EXC_ANY_NAN]       = a_nan_s | b_nan_s;
    s1_next_s.exc[EXC_A_INF]         = a_inf_s;
    s1_next_s.exc[EXC_B_INF]         = b_inf_s;
    s1_next_s.exc[EXC_ANY]           = a_nan_s | b_nan_s | a_inf_s | b_inf_s;
  end

  // Stage-1 register bank; a cycle with no InValid leaves a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      s1_r <= '0;
    end else if (adv1_s) begin
      v1_r <= io.InValid;
      s1_r <= s1_next_s;
    end
  end

  fp_align_shifter u_align (
    .mant         (s1_r.mmin),
    .shift        (s1_r.shift),
    .mant_aligned (mmin_aligned_s),
    .grs          (grs_s)
  );

  // Stage-2 register bank; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_r <= 1'b0;
      s2_r <= '0;
    end else if (adv2_s) begin
      v2_r        <= v1_r;
      s2_r.sa     <= s1_r.sa;
      s2_r.sb     <= s1_r.sb;
      s2_r.ctrl   <= s1_r.ctrl;
      s2_r.op_eff <= s1_r.op_eff;
      s2_r.max_ab <= s1_r.max_ab;
      s2_r.emax   <= s1_r.emax;
      s2_r.mmax   <= s1_r.mmax;
      s2_r.mmin   <= mmin_aligned_s;
      s2_r.grs    <= grs_s;
      s2_r.exc    <= s1_r.exc;
    end
  end

  assign io.OutValid = v2_r;
  assign io.Sa       = s2_r.sa;
  assign io.Sb       = s2_r.sb;
  assign io.CtrlO    = s2_r.ctrl;
  assign io.OpEff    = s2_r.op_eff;
  assign io.MaxAB    = s2_r.max_ab;
  assign io.Emax     = s2_r.emax;
  assign io.Mmax     = s2_r.mmax;
  assign io.Mmin     = s2_r.mmin;
  assign io.GRS      = s2_r.grs;
  assign io.InputExc = s2_r.exc;

endmodule

// File: tb/tb_fp_addsub_prealign.sv
// Self-checking bench for fp_addsub_prealign: directed vectors, randomized
// handshake streams against an arithmetic reference model, stall and reset flush.
module tb_fp_addsub_prealign;

  typedef struct packed {
    logic        sa;
    logic        sb;
    logic        ctrlo;
    logic        op_eff;
    logic        max_ab;
    logic [7:0]  emax;
    logic [23:0] mmax;
    logic [23:0] mmin;
    logic [2:0]  grs;
    logic [4:0]  exc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  fp_addsub_prealign_if io();

  fp_addsub_prealign dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  // Reference: real-number alignment of the smaller significand, written in integers.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    res_t r;
    int unsigned ea, eb, ma, mb, emx, emn, mx, mn, sh;
    longint unsigned full, kept, lost;
    logic a_nan, b_nan, a_inf, b_inf;
    r = '0;
    ea = 32'(a[30:23]);
    eb = 32'(b[30:23]);
    ma = (ea == 0) ? 0 : (32'h0080_0000 + 32'(a[22:0]));
    mb = (eb == 0) ? 0 : (32'h0080_0000 + 32'(b[22:0]));
    r.sa = a[31];
    r.sb = b[31];
    r.ctrlo = c;
    r.op_eff = c ^ a[31] ^ b[31];
    r.max_ab = (32'(b[30:0]) > 32'(a[30:0]));
    if (r.max_ab) begin
      emx = eb; mx = mb; emn = ea; mn = ma;
    end else begin
      emx = ea; mx = ma; emn = eb; mn = mb;
    end
    sh = emx - emn;
    r.emax = 8'(emx);
    r.mmax = 24'(mx);
    if (sh >= 27) begin
      r.mmin = 24'd0;
      r.grs = {2'b00, mn != 0};
    end else begin
      full = 64'(mn) * 64'd8;
      kept = full >> sh;
      lost = full & ((64'd1 << sh) - 64'd1);
      r.mmin = 24'(kept >> 3);
      r.grs = 3'(kept);
      if (lost != 0) r.grs[0] = 1'b1;
    end
    a_inf = (ea == 255) && (a[22:0] == 23'd0);
    b_inf = (eb == 255) && (b[22:0] == 23'd0);
    a_nan = (ea == 255) && (a[22:0] != 23'd0);
    b_nan = (eb == 255) && (b[22:0] != 23'd0);
    r.exc = {a_inf & b_inf & r.op_eff, a_nan | b_nan, a_inf, b_inf, a_nan | b_nan | a_inf | b_inf};
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    r = {io.Sa, io.Sb, io.CtrlO, io.OpEff, io.MaxAB, io.Emax, io.Mmax, io.Mmin, io.GRS, io.InputExc};
    return r;
  endfunction

  function automatic logic [31:0] rand_operand(input logic [31:0] near);
    logic [31:0] x;
    int e;
    x = $urandom;
    case ($urandom_range(0, 9))
      0: x = {x[31], 31'd0};
      1: x = {x[31], 8'hFF, 23'd0};
      2: x = {x[31], 8'hFF, x[22:1], 1'b1};
      3: x = {x[31], 8'h00, x[22:0]};
      4: x = x;
      default: begin
        e = int'(near[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        x = {x[31], 8'(e), x[22:0]};
      end
    endcase
    return x;
  endfunction

  // Applies inputs just after a falling edge; outputs are then stable to sample.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic ordy);
    @(negedge clk);
    io.InValid = iv;
    io.A = a;
    io.B = b;
    io.Ctrl = c;
    io.OutReady = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (io.OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %b want 0", io.OutValid); end
    checks++;
    if (io.InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got %b want 1", io.InReady); end
    checks++;
    if (observe() !== res_t'(0)) begin errors++; $display("FAIL reset_data got %h want 0", observe()); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va[6];
    logic [31:0] vb[6];
    logic        vc[6];
    logic [65:0] vexp[6];
    logic [65:0] got;
    res_t o;
    va[0] = 32'h3F800000; vb[0] = 32'h3F800000; vc[0] = 1'b0;
    vexp[0] = {1'b0, 8'h7F, 24'h800000, 24'h800000, 3'b000, 1'b0, 5'b00000};
    va[1] = 32'h3F800000; vb[1] = 32'h33800000; vc[1] = 1'b0;
    vexp[1] = {1'b0, 8'h7F, 24'h800000, 24'h000000, 3'b100, 1'b0, 5'b00000};
    va[2] = 32'h3F800000; vb[2] = 32'h30800000; vc[2] = 1'b0;
    vexp[2] = {1'b0, 8'h7F, 24'h800000, 24'h000000, 3'b001, 1'b0, 5'b00000};
    va[3] = 32'h3F800000; vb[3] = 32'hC0000000; vc[3] = 1'b0;
    vexp[3] = {1'b1, 8'h80, 24'h800000, 24'h400000, 3'b000, 1'b1, 5'b00000};
    va[4] = 32'h7F800000; vb[4] = 32'h7F800000; vc[4] = 1'b1;
    vexp[4] = {1'b0, 8'hFF, 24'h800000, 24'h800000, 3'b000, 1'b1, 5'b10111};
    va[5] = 32'h7FC00000; vb[5] = 32'h00000000; vc[5] = 1'b0;
    vexp[5] = {1'b0, 8'hFF, 24'hC00000, 24'h000000, 3'b000, 1'b0, 5'b01001};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, va[i], vb[i], vc[i], 1'b1);
      checks++;
      if (io.InReady !== 1'b1) begin errors++; $display("FAIL directed_accept[%0d] got %b want 1", i, io.InReady); end
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      checks++;
      if (io.OutValid !== 1'b0) begin errors++; $display("FAIL directed_early[%0d] got %b want 0", i, io.OutValid); end
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      checks++;
      if (io.OutValid !== 1'b1) begin errors++; $display("FAIL directed_latency[%0d] got %b want 1", i, io.OutValid); end
      o = observe();
      got = {o.max_ab, o.emax, o.mmax, o.mmin, o.grs, o.op_eff, o.exc};
      checks++;
      if (got !== vexp[i]) begin errors++; $display("FAIL directed_fields[%0d] got %h want %h", i, got, vexp[i]); end
      checks++;
      if ({o.sa, o.sb, o.ctrlo} !== {va[i][31], vb[i][31], vc[i]}) begin
        errors++; $display("FAIL directed_signs[%0d] got %b want %b", i, {o.sa, o.sb, o.ctrlo}, {va[i][31], vb[i][31], vc[i]});
      end
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa[4];
    logic [31:0] pb[4];
    logic        pc[4];
    res_t got_q[$];
    res_t held, e;
    int idx;
    for (int i = 0; i < 4; i++) begin
      pa[i] = rand_operand(32'h40000000);
      pb[i] = rand_operand(pa[i]);
      pc[i] = 1'($urandom_range(0, 1));
    end
    exp_q.delete();
    cycle(1'b1, pa[0], pb[0], pc[0], 1'b0);
    checks++;
    if (io.InReady !== 1'b1) begin errors++; $display("FAIL b2b_accept0 got %b want 1", io.InReady); end
    exp_q.push_back(model(pa[0], pb[0], pc[0]));
    cycle(1'b1, pa[1], pb[1], pc[1], 1'b0);
    checks++;
    if (io.InReady !== 1'b1) begin errors++; $display("FAIL b2b_accept1 got %b want 1", io.InReady); end
    exp_q.push_back(model(pa[1], pb[1], pc[1]));
    held = observe();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, pa[2], pb[2], pc[2], 1'b0);
      checks++;
      if (io.InReady !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready[%0d] got %b want 0", k, io.InReady); end
      checks++;
      if (io.OutValid !== 1'b1) begin errors++; $display("FAIL b2b_stall_valid[%0d] got %b want 1", k, io.OutValid); end
      if (k > 0) begin
        checks++;
        if (observe() !== held) begin errors++; $display("FAIL b2b_stall_hold[%0d] got %h want %h", k, observe(), held); end
      end
      held = observe();
    end
    idx = 2;
    for (int n = 0; n < 30 && got_q.size() < 4; n++) begin
      cycle(idx < 4, pa[idx % 4], pb[idx % 4], pc[idx % 4], 1'b1);
      if (io.OutValid) got_q.push_back(observe());
      if (idx < 4 && io.InReady) begin
        exp_q.push_back(model(pa[idx], pb[idx], pc[idx]));
        idx++;
      end
    end
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[i] !== e) begin errors++; $display("FAIL b2b_order[%0d] got %h want %h", i, got_q[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic        iv, ordy, c, exp_ready, was_stalled;
    logic [31:0] a, b;
    res_t        prev, e;
    int          delivered;
    exp_q.delete();
    was_stalled = 1'b0;
    prev = '0;
    delivered = 0;
    for (int n = 0; n < 400; n++) begin
      iv = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      a = rand_operand(32'h3F800000);
      b = rand_operand(a);
      if ($urandom_range(0, 1) == 1) {a, b} = {b, a};
      c = 1'($urandom_range(0, 1));
      cycle(iv, a, b, c, ordy);
      exp_ready = (exp_q.size() < 2) || ordy;
      checks++;
      if (io.InReady !== exp_ready) begin
        errors++; $display("FAIL rand_inready[%0d] got %b want %b", n, io.InReady, exp_ready);
      end
      if (was_stalled) begin
        checks++;
        if (io.OutValid !== 1'b1 || observe() !== prev) begin
          errors++; $display("FAIL rand_hold[%0d] got %b/%h want 1/%h", n, io.OutValid, observe(), prev);
        end
      end
      if (io.OutValid && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra[%0d] got %h want none", n, observe());
        end else begin
          e = exp_q.pop_front();
          delivered++;
          if (observe() !== e) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", n, observe(), e); end
        end
      end
      was_stalled = io.OutValid && !ordy;
      prev = observe();
      if (iv && io.InReady) exp_q.push_back(model(a, b, c));
    end
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      if (io.OutValid) begin
        e = exp_q.pop_front();
        delivered++;
        checks++;
        if (observe() !== e) begin errors++; $display("FAIL rand_drain[%0d] got %h want %h", n, observe(), e); end
      end
    end
    checks++;
    if (exp_q.size() != 0 || delivered < 50) begin
      errors++; $display("FAIL rand_complete got pending=%0d delivered=%0d want 0/>=50", exp_q.size(), delivered);
    end
  endtask

  task automatic test_reset_flush();
    int seen;
    cycle(1'b1, 32'h40400000, 32'h3F000000, 1'b0, 1'b0);
    cycle(1'b1, 32'h41200000, 32'hC1200000, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (io.InReady !== 1'b0 || io.OutValid !== 1'b1) begin
      errors++; $display("FAIL flush_full got rdy=%b vld=%b want 0/1", io.InReady, io.OutValid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (io.OutValid !== 1'b0) begin errors++; $display("FAIL flush_outvalid got %b want 0", io.OutValid); end
    checks++;
    if (io.InReady !== 1'b1) begin errors++; $display("FAIL flush_inready got %b want 1", io.InReady); end
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      if (io.OutValid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_stale got %0d want 0", seen); end
  endtask

  initial begin
    io.InValid = 1'b0;
    io.A = 32'd0;
    io.B = 32'd0;
    io.Ctrl = 1'b0;
    io.OutReady = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
